// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: predicts each word from the previous one and tracks lock/errors.
// Optional err_sticky output enabled by defining PRBS_CHECKER_STICKY_EN.
module prbs_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             clr_count,
    output logic             locked,
    output logic             error,
`ifdef PRBS_CHECKER_STICKY_EN
    output logic             err_sticky,
`endif
    output logic [CNT_W-1:0] err_count
);

    localparam int MR_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] prev, prev_d, pred;
    logic [MR_W-1:0]  match_run, match_d;
    logic [MS_W-1:0]  miss_run, miss_d;
    logic [CNT_W-1:0] cnt_d;
    logic             err_d;

    assign pred = {prev[WIDTH-2:0], ^(prev & TAPS)};

    always_comb begin
        state_d = state;
        prev_d  = prev;
        match_d = match_run;
        miss_d  = miss_run;
        err_d   = 1'b0;
        if (data_valid) begin
            case (state)
                IDLE: begin
                    prev_d  = data_in;
                    state_d = HUNT;
                end
                HUNT: begin
                    prev_d = data_in;
                    // zero word never counts, so a stuck-at-zero line cannot lock
                    if (data_in == pred && data_in != '0) begin
                        if (match_run == MR_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                            match_d = MR_W'(LOCK_CNT);
                        end else begin
                            match_d = match_run + MR_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // flywheel on the prediction so one bad word costs one error
                    prev_d = pred;
                    if (data_in != pred) begin
                        err_d = 1'b1;
                        if (miss_run == MS_W'(LOSS_CNT - 1)) begin
                            state_d = HUNT;
                            match_d = '0;
                            miss_d  = '0;
                            prev_d  = data_in;
                        end else begin
                            miss_d = miss_run + MS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = err_count;
        if (clr_count)
            cnt_d = '0;
        else if (err_d && err_count != '1)
            cnt_d = err_count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '0;
            match_run <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            prev      <= prev_d;
            match_run <= match_d;
            miss_run  <= miss_d;
            locked    <= (state_d == LOCKED);
            error     <= err_d;
            err_count <= cnt_d;
        end
    end

`ifdef PRBS_CHECKER_STICKY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_sticky <= 1'b0;
        else if (err_d)
            err_sticky <= 1'b1;
        else if (clr_count)
            err_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed scenarios plus randomized traffic against a behavioural model.
module tb_prbs_checker;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int CNT_MAX  = 65535;

    logic        clk = 1'b0;
    logic        reset, data_valid, clr_count;
    logic [7:0]  data_in;
    logic        locked, error;
    logic [15:0] err_count;
`ifdef PRBS_CHECKER_STICKY_EN
    logic        err_sticky;
`endif

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clr_count(clr_count), .locked(locked), .error(error),
`ifdef PRBS_CHECKER_STICKY_EN
        .err_sticky(err_sticky),
`endif
        .err_count(err_count)
    );

    // model: mode 0=idle 1=hunt 2=locked
    int         m_mode, m_mr, m_ms, m_cnt;
    logic [7:0] m_prev;
    bit         m_err, m_sticky;
    int         n_pass = 0, n_total = 0;
    bit         cmp_en = 0;

    function automatic logic [7:0] nw(input logic [7:0] w);
        int fb = 0;
        for (int i = 0; i < 8; i++) fb ^= (w[i] & TAPS[i]);
        return 8'(((int'(w) * 2) % 256) + fb);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_mr = 0; m_ms = 0; m_cnt = 0; m_prev = 0; m_err = 0; m_sticky = 0;
    endtask

    task automatic model_update(input bit v, input logic [7:0] d, input bit clr);
        logic [7:0] p;
        m_err = 0;
        p = nw(m_prev);
        if (v) begin
            if (m_mode == 0) begin
                m_prev = d; m_mode = 1;
            end else if (m_mode == 1) begin
                if (d == p && d != 0) begin
                    m_mr++;
                    if (m_mr == LOCK_CNT) begin m_mode = 2; m_ms = 0; end
                end else m_mr = 0;
                m_prev = d;
            end else begin
                m_prev = p;
                if (d != p) begin
                    m_err = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                    m_ms++;
                    if (m_ms == LOSS_CNT) begin m_mode = 1; m_mr = 0; m_ms = 0; m_prev = d; end
                end else m_ms = 0;
            end
        end
        if (clr) m_cnt = 0;
        if (m_err) m_sticky = 1;
        else if (clr) m_sticky = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit clr);
        @(negedge clk);
        data_valid = v; data_in = d; clr_count = clr;
        @(posedge clk);
        model_update(v, d, clr);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; data_valid = 0; clr_count = 0; data_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("locked", locked, int'(m_mode == 2));
            chk("error", error, int'(m_err));
            chk("err_count", err_count, m_cnt);
`ifdef PRBS_CHECKER_STICKY_EN
            chk("err_sticky", err_sticky, int'(m_sticky));
`endif
        end
    end

    initial begin
        logic [7:0] s;
        bit v, c;
        logic [7:0] d;
        reset = 1; data_valid = 0; clr_count = 0; data_in = 0;
        model_reset();
        #1;
        chk("reset_locked", locked, 0);
        chk("reset_error", error, 0);
        chk("reset_cnt", err_count, 0);
        chk("model_pin_8A", nw(8'h8A), 8'h14);
        chk("model_pin_52", nw(8'h52), 8'hA5);
        repeat (2) @(negedge clk);
        reset = 0;
        cmp_en = 1;

        // lock acquisition on the reference stream
        step(1, 8'h8A, 0); step(1, 8'h14, 0); step(1, 8'h29, 0); step(1, 8'h52, 0);
        chk("unlocked_before_A5", locked, 0);
        step(1, 8'hA5, 0);
        chk("locked_after_A5", locked, 1);
        step(1, 8'h4A, 0);
        chk("cnt_after_lock", err_count, 0);

        // single corrupted word
        step(1, 8'h00, 0);
        chk("corrupt_error", error, 1);
        step(1, nw(m_prev), 0);
        chk("corrupt_error_once", error, 0);
        chk("corrupt_cnt", err_count, 1);
        chk("corrupt_still_locked", locked, 1);

        // three consecutive bad words lose lock, clean stream re-locks
        step(1, nw(m_prev), 1);
        chk("clr_cnt", err_count, 0);
        step(1, 8'h00, 0); step(1, 8'h00, 0);
        chk("loss_locked_2", locked, 1);
        step(1, 8'h00, 0);
        chk("loss_unlocked", locked, 0);
        chk("loss_cnt", err_count, 3);
        s = 8'h5C;
        for (int i = 0; i < 4; i++) begin step(1, s, 0); s = nw(s); end
        chk("relock_not_yet", locked, 0);
        step(1, s, 0);
        chk("relock", locked, 1);

        // stuck-at-zero stream
        do_reset();
        repeat (10) step(1, 8'h00, 0);
        chk("zero_unlocked", locked, 0);
        chk("zero_cnt", err_count, 0);

        // gaps in data_valid with garbage data, then clr vs mismatch
        do_reset();
        s = 8'h8A;
        step(1, s, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 8'($urandom), 0);
            s = nw(s);
            step(1, s, 0);
        end
        chk("gap_locked", locked, 1);
        step(1, 8'h00, 1);
        chk("clr_beats_inc", err_count, 0);
        chk("clr_error", error, 1);
        step(1, nw(m_prev), 0);

        // build five errors then reset mid-cycle
        for (int i = 0; i < 5; i++) begin step(1, 8'h00, 0); step(1, nw(m_prev), 0); end
        chk("five_cnt", err_count, 5);
        chk("five_locked", locked, 1);
        #2 reset = 1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_cnt", err_count, 0);
`ifdef PRBS_CHECKER_STICKY_EN
        chk("async_sticky", err_sticky, 0);
`endif
        model_reset();
        data_valid = 0; clr_count = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        s = 8'h33;
        for (int i = 0; i < 5; i++) begin step(1, s, 0); s = nw(s); end
        step(1, 8'h00, 0);
`ifdef PRBS_CHECKER_STICKY_EN
        step(1, nw(m_prev), 0);
        chk("sticky_set", err_sticky, 1);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 19))
                0:       d = 8'h00;
                1, 2:    d = 8'($urandom);
                default: d = nw(m_prev);
            endcase
            if (m_mode != 2 && d == 0) d = 8'h01;
            step(v, d, c);
        end

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
